retire_map_table: RTL and testbench
===================================

Name: retire_map_table

Overview:
- Retirement (architectural) register map table (RRAT).
- Takes up to WAYS in-order retirements per cycle, each an arch-dest/phys-dest pair, and updates the committed arch->phys map.
- Drives the freelist's RRAT ports: entering phys regs on the *_new ports, displaced phys regs on the *_old ports.
- Supplies the committed map to the RAT for mis-branch recovery.

Parameters:
- WAYS, 4, retire width; lane 0 = oldest.
- PRF, 64, physical register count; phys index width = $clog2(PRF).
- ARF, 32, architectural register count; arch index width = $clog2(ARF).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- except  in  1  mis-branch flush, same cycle the freelist sees except
- retire_valid  in  WAYS  lane retires an instruction with a destination register
- retire_arch_idx  in  WAYS x $clog2(ARF)  arch destination per lane
- retire_phys_idx  in  WAYS x $clog2(PRF)  phys destination allocated at rename
- reg_idx_wr_RRAT_new  out  WAYS x $clog2(PRF)  phys regs entering the RRAT
- wr_en_RRAT_new  out  WAYS  valid for reg_idx_wr_RRAT_new
- reg_idx_wr_RRAT_old  out  WAYS x $clog2(PRF)  phys regs leaving the RRAT (freed)
- wr_en_RRAT_old  out  WAYS  valid for reg_idx_wr_RRAT_old
- arch_map  out  ARF x $clog2(PRF)  registered committed map
- restore_map  out  ARF x $clog2(PRF)  next-state map, sampled by the RAT on except
- instret  out  64  retired-lane counter
- map_error  out  1  sticky consistency error (see Optional Feature)

Behaviour:
- Reset (reset low, async):
  - map[i] = i for all i < ARF.
  - instret = 0; map_error = 0.
  - All *_RRAT_* outputs are combinational and are 0 while retire_valid = 0.
- Effective lane: retire_valid[i] && retire_arch_idx[i] != 0. x0 retirements never allocate.
- Effective lane i outputs (combinational, zero latency):
  - wr_en_RRAT_new[i] = 1; reg_idx_wr_RRAT_new[i] = retire_phys_idx[i].
  - wr_en_RRAT_old[i] = 1; reg_idx_wr_RRAT_old[i] = displaced phys reg.
- Non-effective lane: all four lane outputs are 0.
- Displaced reg for lane i is retire_phys_idx[j] of the youngest effective lane j < i with the same arch idx; if no such lane, it is map[arch].
- Intra-group: if lanes 0 and 2 both write r5, lane 2's old = lane 0's phys. The final map takes lane 2's phys.
- restore_map = map after applying all effective lanes in lane order. arch_map <= restore_map at each posedge.
- except:
  - Same-cycle retirements still commit and still drive the freelist ports.
  - The map is otherwise unchanged; the RRAT holds no speculative state.
  - The RAT copies restore_map in the except cycle.
- instret += popcount(retire_valid), x0 lanes included. 64-bit, wraps modulo 2^64.
- retire_valid need not be contiguous; gaps are legal and ignored.
- Reset asserted mid-operation: map returns to identity immediately, independent of clock.

Optional Feature:
- Macro: RRAT_CHECK_EN.
- Defined: map_error sets (sticky until reset) when any of the following occurs on an effective lane:
  - retire_phys_idx equals a phys reg currently in map (excluding the slot it displaces);
  - two effective lanes in one cycle carry equal phys idx;
  - retire_phys_idx < ARF while that value is still mapped.
- Defined: simulation builds also fire an $error on the same conditions.
- Undefined: map_error is tied 0 and no check logic is built.

Test Plan:
- Reset release, no retire -> arch_map[i] = i; all wr_en outputs 0; instret = 0.
- Lane0 r3->p40, lane1 r7->p41 -> new = {40, 41}, old = {3, 7}, both wr_en set. Next cycle arch_map[3] = 40, arch_map[7] = 41; instret = 2.
- Lanes 0, 1, 3 all write r5 with p50, p51, p52 (lane 2 invalid) -> old = {5, 50, -, 51}; wr_en_old = 4'b1011; arch_map[5] = 52; instret = 3.
- Lane0 retires x0 with p60 -> all lane0 outputs 0; map unchanged; instret += 1.
- except with lane0 r1->p33 -> restore_map[1] = 33 in the same cycle; freelist ports show new = 33, old = 1; next cycle arch_map[1] = 33.
- RRAT_CHECK_EN: retire r2->p40 while r3 maps to p40 -> map_error = 1 next cycle and held; cleared only by reset low.

Source files
------------

// File: rtl/retire_map_table_if.sv
// Retire-to-RRAT bus: per-lane retirement requests in, freelist RRAT write ports out.
//   retire_valid / retire_arch_idx / retire_phys_idx : retirement group, lane 0 oldest
//   reg_idx_wr_RRAT_new / wr_en_RRAT_new             : phys regs entering the committed map
//   reg_idx_wr_RRAT_old / wr_en_RRAT_old             : phys regs displaced (freed)
// master = retirement source / freelist side, slave = retire_map_table.
interface retire_map_table_if #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned PRF  = 64,
  parameter int unsigned ARF  = 32
);
  localparam int unsigned PIW = $clog2(PRF);
  localparam int unsigned AIW = $clog2(ARF);

  logic [WAYS-1:0]           retire_valid;
  logic [WAYS-1:0][AIW-1:0]  retire_arch_idx;
  logic [WAYS-1:0][PIW-1:0]  retire_phys_idx;
  logic [WAYS-1:0][PIW-1:0]  reg_idx_wr_RRAT_new;
  logic [WAYS-1:0]           wr_en_RRAT_new;
  logic [WAYS-1:0][PIW-1:0]  reg_idx_wr_RRAT_old;
  logic [WAYS-1:0]           wr_en_RRAT_old;

  modport master (
    output retire_valid, retire_arch_idx, retire_phys_idx,
    input  reg_idx_wr_RRAT_new, wr_en_RRAT_new, reg_idx_wr_RRAT_old, wr_en_RRAT_old
  );

  modport slave (
    input  retire_valid, retire_arch_idx, retire_phys_idx,
    output reg_idx_wr_RRAT_new, wr_en_RRAT_new, reg_idx_wr_RRAT_old, wr_en_RRAT_old
  );
endinterface

// File: rtl/retire_map_table.sv
// Retirement register alias table (RRAT): committed arch->phys map.
// Applies up to WAYS in-order retirements per cycle, reports entering/displaced
// phys regs to the freelist combinationally, and exposes the next-state map for
// mis-branch recovery.
// Ports:
//   clock, reset (async, active low), except (mis-branch flush, informational here)
//   rt          : retire_map_table_if.slave (retire group in, freelist RRAT ports out)
//   arch_map    : registered committed map
//   restore_map : combinational next-state map (RAT samples it on except)
//   instret     : 64-bit count of valid retire lanes (x0 included)
//   map_error   : sticky allocation-consistency error
// Optional build macro: RRAT_CHECK_EN enables the map_error checker; when
// undefined map_error is tied low and no check logic exists.
module retire_map_table #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned PRF  = 64,
  parameter int unsigned ARF  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            except,
  retire_map_table_if.slave               rt,
  output logic [ARF-1:0][$clog2(PRF)-1:0] arch_map,
  output logic [ARF-1:0][$clog2(PRF)-1:0] restore_map,
  output logic [63:0]                     instret,
  output logic                            map_error
);
  localparam int unsigned PIW = $clog2(PRF);
  localparam int unsigned AIW = $clog2(ARF);
  localparam int unsigned CW  = $clog2(WAYS + 1);

  logic [ARF-1:0][PIW-1:0]  map_c;
  logic [WAYS-1:0]          new_en_c;
  logic [WAYS-1:0][PIW-1:0] new_idx_c;
  logic [WAYS-1:0]          old_en_c;
  logic [WAYS-1:0][PIW-1:0] old_idx_c;
  logic [CW-1:0]            retire_cnt_c;

  // The map holds no speculative state, so a flush does not alter the update.
  logic unused_except;
  assign unused_except = except;

  // Walk lanes oldest-first; map_c carries earlier lanes' writes, so a lane's
  // displaced reg is the youngest older same-arch lane's phys, else the committed entry.
  always_comb begin
    map_c     = arch_map;
    new_en_c  = '0;
    new_idx_c = '0;
    old_en_c  = '0;
    old_idx_c = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (rt.retire_valid[i] && (rt.retire_arch_idx[i] != '0)) begin
        new_en_c[i]                  = 1'b1;
        new_idx_c[i]                 = rt.retire_phys_idx[i];
        old_en_c[i]                  = 1'b1;
        old_idx_c[i]                 = map_c[rt.retire_arch_idx[i]];
        map_c[rt.retire_arch_idx[i]] = rt.retire_phys_idx[i];
      end
    end
  end

  assign rt.wr_en_RRAT_new      = new_en_c;
  assign rt.reg_idx_wr_RRAT_new = new_idx_c;
  assign rt.wr_en_RRAT_old      = old_en_c;
  assign rt.reg_idx_wr_RRAT_old = old_idx_c;
  assign restore_map            = map_c;

  // Every valid lane counts as retired, including x0 destinations.
  always_comb begin
    retire_cnt_c = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      retire_cnt_c = retire_cnt_c + CW'(rt.retire_valid[i]);
    end
  end

  // Committed map and retire counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < int'(ARF); a++) begin
        arch_map[a] <= PIW'(a);
      end
      instret <= '0;
    end else begin
      arch_map <= map_c;
      instret  <= instret + 64'(retire_cnt_c);
    end
  end

`ifdef RRAT_CHECK_EN
  logic                    err_c;
  logic [ARF-1:0][PIW-1:0] chk_map;

  // Flags an incoming phys reg that is still live elsewhere in the map, one that
  // aliases an arch-identity reg still mapped, or a duplicate within the group.
  always_comb begin
    err_c   = 1'b0;
    chk_map = arch_map;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (rt.retire_valid[i] && (rt.retire_arch_idx[i] != '0)) begin
        for (int a = 0; a < int'(ARF); a++) begin
          if (chk_map[a] == rt.retire_phys_idx[i]) begin
            if (AIW'(a) != rt.retire_arch_idx[i]) err_c = 1'b1;
            if (32'(rt.retire_phys_idx[i]) < ARF)  err_c = 1'b1;
          end
        end
        for (int j = 0; j < i; j++) begin
          if (rt.retire_valid[j] && (rt.retire_arch_idx[j] != '0) &&
              (rt.retire_phys_idx[j] == rt.retire_phys_idx[i])) begin
            err_c = 1'b1;
          end
        end
        chk_map[rt.retire_arch_idx[i]] = rt.retire_phys_idx[i];
      end
    end
  end

  // Sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      map_error <= 1'b0;
    end else begin
      if (err_c) map_error <= 1'b1;
`ifndef SYNTHESIS
      if (err_c) $error("retire_map_table: inconsistent phys allocation on retire");
`endif
    end
  end
`else
  assign map_error = 1'b0;
`endif

endmodule

// File: tb/tb_retire_map_table.sv
module tb_retire_map_table;
  localparam int unsigned WAYS = 4;
  localparam int unsigned PRF  = 64;
  localparam int unsigned ARF  = 32;
  localparam int unsigned PIW  = 6;
  localparam int unsigned AIW  = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic except = 1'b0;
  always #5 clock = ~clock;

  retire_map_table_if #(.WAYS(WAYS), .PRF(PRF), .ARF(ARF)) rif ();

  logic [ARF-1:0][PIW-1:0] arch_map;
  logic [ARF-1:0][PIW-1:0] restore_map;
  logic [63:0]             instret;
  logic                    map_error;

  retire_map_table #(.WAYS(WAYS), .PRF(PRF), .ARF(ARF)) dut (
    .clock       (clock),
    .reset       (reset),
    .except      (except),
    .rt          (rif),
    .arch_map    (arch_map),
    .restore_map (restore_map),
    .instret     (instret),
    .map_error   (map_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_map(input string name, input logic [ARF*PIW-1:0] act, input logic [ARF*PIW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ex, input logic [3:0] vld,
                       input logic [3:0][AIW-1:0] ar, input logic [3:0][PIW-1:0] ph);
    except               = ex;
    rif.retire_valid     = vld;
    rif.retire_arch_idx  = ar;
    rif.retire_phys_idx  = ph;
  endtask

  typedef struct {
    logic                ex;
    logic [3:0]          vld;
    logic [3:0][AIW-1:0] ar;
    logic [3:0][PIW-1:0] ph;
    logic [3:0]          en;
    logic [3:0][PIW-1:0] nw;
    logic [3:0][PIW-1:0] od;
    int                  i1;
    int                  v1;
    int                  i2;
    int                  v2;
    longint unsigned     ir;
  } vec_t;

  vec_t vecs [6];

  // Reference model state
  logic [PIW-1:0]          mmap [ARF];
  longint unsigned         mir;
  logic [3:0]              r_vld;
  logic [3:0][AIW-1:0]     r_ar;
  logic [3:0][PIW-1:0]     r_ph;
  logic [3:0]              e_en;
  logic [3:0][PIW-1:0]     e_nw;
  logic [3:0][PIW-1:0]     e_od;
  logic [ARF-1:0][PIW-1:0] e_rm;
  logic [ARF-1:0][PIW-1:0] ident;
  logic                    r_ex;

  function automatic bit is_free(input logic [PIW-1:0] p, input int upto);
    for (int a = 0; a < int'(ARF); a++) if (mmap[a] == p) return 1'b0;
    for (int j = 0; j < upto; j++) if (r_ph[j] == p) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    vecs[0] = '{ex:1'b0, vld:4'b0011, ar:{5'd0, 5'd0, 5'd7, 5'd3}, ph:{6'd0, 6'd0, 6'd41, 6'd40},
                en:4'b0011, nw:{6'd0, 6'd0, 6'd41, 6'd40}, od:{6'd0, 6'd0, 6'd7, 6'd3},
                i1:3, v1:40, i2:7, v2:41, ir:2};
    vecs[1] = '{ex:1'b0, vld:4'b1011, ar:{5'd5, 5'd5, 5'd5, 5'd5}, ph:{6'd52, 6'd0, 6'd51, 6'd50},
                en:4'b1011, nw:{6'd52, 6'd0, 6'd51, 6'd50}, od:{6'd51, 6'd0, 6'd50, 6'd5},
                i1:5, v1:52, i2:3, v2:40, ir:5};
    vecs[2] = '{ex:1'b0, vld:4'b0001, ar:{5'd0, 5'd0, 5'd0, 5'd0}, ph:{6'd0, 6'd0, 6'd0, 6'd60},
                en:4'b0000, nw:'0, od:'0,
                i1:0, v1:0, i2:5, v2:52, ir:6};
    vecs[3] = '{ex:1'b1, vld:4'b0001, ar:{5'd0, 5'd0, 5'd0, 5'd1}, ph:{6'd0, 6'd0, 6'd0, 6'd33},
                en:4'b0001, nw:{6'd0, 6'd0, 6'd0, 6'd33}, od:{6'd0, 6'd0, 6'd0, 6'd1},
                i1:1, v1:33, i2:7, v2:41, ir:7};
    vecs[4] = '{ex:1'b0, vld:4'b1000, ar:{5'd3, 5'd0, 5'd0, 5'd0}, ph:{6'd45, 6'd0, 6'd0, 6'd0},
                en:4'b1000, nw:{6'd45, 6'd0, 6'd0, 6'd0}, od:{6'd40, 6'd0, 6'd0, 6'd0},
                i1:3, v1:45, i2:1, v2:33, ir:8};
    vecs[5] = '{ex:1'b0, vld:4'b1111, ar:{5'd10, 5'd9, 5'd0, 5'd9}, ph:{6'd37, 6'd36, 6'd35, 6'd34},
                en:4'b1101, nw:{6'd37, 6'd36, 6'd0, 6'd34}, od:{6'd10, 6'd34, 6'd0, 6'd9},
                i1:9, v1:36, i2:10, v2:37, ir:12};

    for (int a = 0; a < int'(ARF); a++) ident[a] = PIW'(a);

    drive(1'b0, 4'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #2;
    chk_map("reset_arch_map", arch_map, ident);
    chk("reset_instret", instret, 64'd0);
    chk("reset_wr_en_new", {60'd0, rif.wr_en_RRAT_new}, 64'd0);
    chk("reset_wr_en_old", {60'd0, rif.wr_en_RRAT_old}, 64'd0);
    chk("reset_map_error", {63'd0, map_error}, 64'd0);
    @(posedge clock); #1;

    // Directed vector table, applied back to back from the identity map
    for (int k = 0; k < 6; k++) begin
      drive(vecs[k].ex, vecs[k].vld, vecs[k].ar, vecs[k].ph);
      #2;
      chk($sformatf("v%0d_wr_en_new", k), {60'd0, rif.wr_en_RRAT_new}, {60'd0, vecs[k].en});
      chk($sformatf("v%0d_wr_en_old", k), {60'd0, rif.wr_en_RRAT_old}, {60'd0, vecs[k].en});
      chk($sformatf("v%0d_new", k), {40'd0, rif.reg_idx_wr_RRAT_new}, {40'd0, vecs[k].nw});
      chk($sformatf("v%0d_old", k), {40'd0, rif.reg_idx_wr_RRAT_old}, {40'd0, vecs[k].od});
      chk($sformatf("v%0d_restore_a", k), {58'd0, restore_map[vecs[k].i1]}, 64'(vecs[k].v1));
      chk($sformatf("v%0d_restore_b", k), {58'd0, restore_map[vecs[k].i2]}, 64'(vecs[k].v2));
      @(posedge clock); #1;
      chk($sformatf("v%0d_arch_map_a", k), {58'd0, arch_map[vecs[k].i1]}, 64'(vecs[k].v1));
      chk($sformatf("v%0d_arch_map_b", k), {58'd0, arch_map[vecs[k].i2]}, 64'(vecs[k].v2));
      chk($sformatf("v%0d_instret", k), instret, vecs[k].ir);
      drive(1'b0, 4'b0, '0, '0);
    end

    // Idle: freelist ports stay quiet, map holds
    #2;
    chk("idle_wr_en", {60'd0, rif.wr_en_RRAT_new | rif.wr_en_RRAT_old}, 64'd0);
    @(posedge clock); #1;
    chk("idle_instret", instret, 64'd12);

    // Asynchronous reset mid-operation, checked before any clock edge
    reset = 1'b0;
    #1;
    chk_map("async_reset_map", arch_map, ident);
    chk("async_reset_instret", instret, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Randomized legal retirement groups against the reference model
    for (int a = 0; a < int'(ARF); a++) mmap[a] = PIW'(a);
    mir = 0;
    for (int c = 0; c < 400; c++) begin
      r_ex = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < 4; l++) begin
        r_vld[l] = 1'($urandom_range(0, 1));
        r_ar[l]  = ($urandom_range(0, 1) != 0) ? AIW'($urandom_range(0, 3)) : AIW'($urandom_range(0, 31));
        r_ph[l]  = PIW'($urandom_range(0, 63));
        for (int t = 0; t < 500 && !is_free(r_ph[l], l); t++) r_ph[l] = PIW'($urandom_range(0, 63));
      end
      for (int i = 0; i < 4; i++) begin
        e_en[i] = r_vld[i] && (r_ar[i] != '0);
        e_nw[i] = e_en[i] ? r_ph[i] : '0;
        e_od[i] = '0;
        if (e_en[i]) begin
          int src;
          src = -1;
          for (int j = i - 1; j >= 0; j--)
            if (src < 0 && r_vld[j] && r_ar[j] != '0 && r_ar[j] == r_ar[i]) src = j;
          e_od[i] = (src >= 0) ? r_ph[src] : mmap[r_ar[i]];
        end
      end
      for (int a = 0; a < int'(ARF); a++) begin
        e_rm[a] = mmap[a];
        for (int i = 0; i < 4; i++)
          if (e_en[i] && int'(r_ar[i]) == a) e_rm[a] = r_ph[i];
      end
      drive(r_ex, r_vld, r_ar, r_ph);
      #2;
      chk("rnd_wr_en_new", {60'd0, rif.wr_en_RRAT_new}, {60'd0, e_en});
      chk("rnd_wr_en_old", {60'd0, rif.wr_en_RRAT_old}, {60'd0, e_en});
      chk("rnd_new", {40'd0, rif.reg_idx_wr_RRAT_new}, {40'd0, e_nw});
      chk("rnd_old", {40'd0, rif.reg_idx_wr_RRAT_old}, {40'd0, e_od});
      chk_map("rnd_restore_map", restore_map, e_rm);
      @(posedge clock); #1;
      for (int a = 0; a < int'(ARF); a++) mmap[a] = e_rm[a];
      mir = mir + longint'($countones(r_vld));
      chk_map("rnd_arch_map", arch_map, e_rm);
      chk("rnd_instret", instret, mir);
    end
    drive(1'b0, 4'b0, '0, '0);
    #2;
    chk("rnd_map_error", {63'd0, map_error}, 64'd0);
    @(posedge clock); #1;

`ifdef RRAT_CHECK_EN
    // Sticky consistency error: r3->p40, then r2->p40 while r3 still holds p40
    reset = 1'b0;
    #2 reset = 1'b1;
    drive(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {6'd0, 6'd0, 6'd0, 6'd40});
    @(posedge clock); #1;
    chk("chk_legal_no_error", {63'd0, map_error}, 64'd0);
    drive(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, {6'd0, 6'd0, 6'd0, 6'd40});
    @(posedge clock); #1;
    chk("chk_error_set", {63'd0, map_error}, 64'd1);
    drive(1'b0, 4'b0, '0, '0);
    @(posedge clock); #1;
    chk("chk_error_held", {63'd0, map_error}, 64'd1);
    reset = 1'b0;
    #1;
    chk("chk_error_cleared", {63'd0, map_error}, 64'd0);
    #1 reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
